// File: rtl/adc_window_stats.sv
// adc_window_stats
//   Reduces the 12-bit ADC sample stream to one statistic per window of
//   2**WINDOW_LOG2 samples and feeds the result to the 7-segment display stage.
//   The statistic is the average, max, min or peak-to-peak value. It can
//   optionally be scaled to millivolts for a 1 V full-scale input.
//
// Ports
//   clock_100Mhz  in   1       system clock, single domain
//   reset         in   1       synchronous, active-high
//   sample_in     in   DATA_W  unsigned ADC code
//   sample_valid  in   1       one sample per high cycle
//   mode          in   2       0 avg, 1 max, 2 min, 3 max-min (captured at window end)
//   freeze        in   1       1 suppresses val updates; windows keep running
//   val           out  DATA_W  displayed value, held between updates
//   val_update    out  1       pulse in the cycle val takes a new value
//   window_done   out  1       pulse one cycle after a window's last sample
module adc_window_stats #(
    parameter int DATA_W      = 12,
    parameter int WINDOW_LOG2 = 10,
    parameter int SCALE_MV    = 0
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [1:0]        mode,
    input  logic              freeze,
    output logic [DATA_W-1:0] val,
    output logic              val_update,
    output logic              window_done
);

    localparam int SUM_W  = DATA_W + WINDOW_LOG2;
    // raw (DATA_W bits) times 1000 (10 bits) never exceeds DATA_W+10 bits.
    localparam int PROD_W = DATA_W + 10;

    typedef enum logic [1:0] {
        MODE_AVG = 2'd0,
        MODE_MAX = 2'd1,
        MODE_MIN = 2'd2,
        MODE_P2P = 2'd3
    } statMode_e;

    // Accumulators for the window currently being filled.
    logic [WINDOW_LOG2-1:0] count_q, count_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [DATA_W-1:0]      max_q, max_d;
    logic [DATA_W-1:0]      min_q, min_d;

    // Values that include the current sample, used both to update the
    // accumulators and to snapshot a closing window.
    logic [SUM_W-1:0]       sumNext;
    logic [DATA_W-1:0]      maxNext;
    logic [DATA_W-1:0]      minNext;
    logic                   windowEnd;

    // Stage 1: snapshot of a completed window.
    logic                   s1Valid_q;
    logic [SUM_W-1:0]       s1Sum_q;
    logic [DATA_W-1:0]      s1Max_q;
    logic [DATA_W-1:0]      s1Min_q;
    statMode_e              s1Mode_q;

    // Stage 2: display register.
    logic [DATA_W-1:0]      val_q;
    logic                   valUpdate_q;

    logic [DATA_W-1:0]      raw;
    logic [PROD_W-1:0]      product;
    logic [DATA_W-1:0]      scaled;

    // The closing sample is folded in, and the accumulators reload in the
    // same cycle, so a sample on the very next cycle opens the new window.
    always_comb begin
        sumNext   = sum_q + SUM_W'(sample_in);
        maxNext   = (sample_in > max_q) ? sample_in : max_q;
        minNext   = (sample_in < min_q) ? sample_in : min_q;
        windowEnd = sample_valid && (count_q == {WINDOW_LOG2{1'b1}});

        count_d = count_q;
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        if (sample_valid) begin
            // count wraps to zero naturally on the last sample of a window.
            count_d = count_q + 1'b1;
            if (windowEnd) begin
                sum_d = '0;
                max_d = '0;
                min_d = '1;
            end else begin
                sum_d = sumNext;
                max_d = maxNext;
                min_d = minNext;
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            count_q <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            min_q   <= '1;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
        end
    end

    // Stage 1 holds the window's totals and the mode seen at its end.
    // All four statistics are tracked all the time, so a mode change in the
    // middle of a window only takes effect here.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Sum_q   <= '0;
            s1Max_q   <= '0;
            s1Min_q   <= '0;
            s1Mode_q  <= MODE_AVG;
        end else begin
            s1Valid_q <= windowEnd;
            if (windowEnd) begin
                s1Sum_q  <= sumNext;
                s1Max_q  <= maxNext;
                s1Min_q  <= minNext;
                s1Mode_q <= statMode_e'(mode);
            end
        end
    end

    // The average is a plain shift because the window length is a power of
    // two. Max >= min holds for any complete window, so max-min cannot
    // underflow.
    always_comb begin
        raw = '0;
        unique case (s1Mode_q)
            MODE_AVG: raw = s1Sum_q[SUM_W-1:WINDOW_LOG2];
            MODE_MAX: raw = s1Max_q;
            MODE_MIN: raw = s1Min_q;
            MODE_P2P: raw = s1Max_q - s1Min_q;
            default:  raw = '0;
        endcase
        product = PROD_W'(raw) * PROD_W'(1000);
        scaled  = (SCALE_MV != 0) ? DATA_W'(product >> 12) : raw;
    end

    // freeze is looked at only when a result is ready to be displayed.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            val_q       <= '0;
            valUpdate_q <= 1'b0;
        end else begin
            valUpdate_q <= s1Valid_q && !freeze;
            if (s1Valid_q && !freeze) begin
                val_q <= scaled;
            end
        end
    end

    assign val         = val_q;
    assign val_update  = valUpdate_q;
    assign window_done = s1Valid_q;

endmodule

// File: tb/tb_adc_window_stats.sv
// tb_adc_window_stats
//   Drives two adc_window_stats instances with a 4-sample window: one shows
//   raw codes and one shows millivolts. Both get the same inputs. Each cycle
//   the outputs are compared against a window-level reference model. Fixed
//   scenarios are followed by a randomized run.
module tb_adc_window_stats;

    localparam int DATA_W = 12;
    localparam int WLOG2  = 2;
    localparam int WIN    = 1 << WLOG2;

    logic              clock_100Mhz;
    logic              reset;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [1:0]        mode;
    logic              freeze;
    logic [DATA_W-1:0] val;
    logic              val_update;
    logic              window_done;
    logic [DATA_W-1:0] valMv;
    logic              valUpdateMv;
    logic              windowDoneMv;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state: the samples of the open window, and the result
    // of a window that closed at the previous edge, waiting for display.
    int winQ[$];
    bit pendValid;
    int pendRaw;
    int expDone;
    int expUpd;
    int expVal;
    int expValMv;

    adc_window_stats #(.DATA_W(DATA_W), .WINDOW_LOG2(WLOG2), .SCALE_MV(0)) dutRaw (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .mode         (mode),
        .freeze       (freeze),
        .val          (val),
        .val_update   (val_update),
        .window_done  (window_done)
    );

    adc_window_stats #(.DATA_W(DATA_W), .WINDOW_LOG2(WLOG2), .SCALE_MV(1)) dutMv (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .mode         (mode),
        .freeze       (freeze),
        .val          (valMv),
        .val_update   (valUpdateMv),
        .window_done  (windowDoneMv)
    );

    initial clock_100Mhz = 1'b0;
    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // The statistic of the full window in winQ, computed directly from the
    // list of samples.
    function automatic int windowStat(input int m);
        int total = 0;
        int hi = 0;
        int lo = 4095;
        foreach (winQ[i]) begin
            total += winQ[i];
            if (winQ[i] > hi) hi = winQ[i];
            if (winQ[i] < lo) lo = winQ[i];
        end
        case (m)
            0:       return total / WIN;
            1:       return hi;
            2:       return lo;
            default: return hi - lo;
        endcase
    endfunction

    // Effect of one clock edge that saw the given inputs. A window closing at
    // an edge is reported the cycle after it, and it is displayed one cycle
    // later unless freeze is high then.
    task automatic modelEdge(input bit r, input bit v, input int s, input int m, input bit f);
        bit closed;
        int closedRaw;
        closed    = 1'b0;
        closedRaw = 0;
        if (r) begin
            winQ.delete();
            pendValid = 1'b0;
            expDone   = 0;
            expUpd    = 0;
            expVal    = 0;
            expValMv  = 0;
        end else begin
            expUpd = 0;
            if (pendValid && !f) begin
                expUpd   = 1;
                expVal   = pendRaw;
                expValMv = (pendRaw * 1000) / 4096;
            end
            if (v) begin
                winQ.push_back(s);
                if (winQ.size() == WIN) begin
                    closed    = 1'b1;
                    closedRaw = windowStat(m);
                    winQ.delete();
                end
            end
            pendValid = closed;
            pendRaw   = closedRaw;
            expDone   = closed ? 1 : 0;
        end
    endtask

    // One clock cycle: drive the inputs, let the edge happen, then compare
    // every output of both instances with the model.
    task automatic applyStimulus(input bit r, input bit v, input int s, input int m, input bit f);
        reset        = r;
        sample_valid = v;
        sample_in    = DATA_W'(s);
        mode         = 2'(m);
        freeze       = f;
        @(posedge clock_100Mhz);
        #1;
        modelEdge(r, v, s, m, f);
        checkOutput("window_done", int'(window_done), expDone);
        checkOutput("val_update", int'(val_update), expUpd);
        checkOutput("val", int'(val), expVal);
        checkOutput("mv_window_done", int'(windowDoneMv), expDone);
        checkOutput("mv_val_update", int'(valUpdateMv), expUpd);
        checkOutput("mv_val", int'(valMv), expValMv);
    endtask

    initial begin
        int samplesA[4] = '{100, 200, 300, 400};
        int samplesB[4] = '{10, 4095, 0, 20};
        int expB[4]     = '{1031, 4095, 0, 4095};
        int modesB[4]   = '{0, 1, 2, 3};
        int samplesC[8] = '{1, 1, 1, 1, 1000, 1000, 1000, 1000};

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        mode         = 2'd0;
        freeze       = 1'b0;
        winQ.delete();
        pendValid = 1'b0;
        pendRaw   = 0;
        expDone   = 0;
        expUpd    = 0;
        expVal    = 0;
        expValMv  = 0;

        // Reset held for two cycles.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_val", int'(val), 0);
        checkOutput("reset_update", int'(val_update), 0);
        checkOutput("reset_done", int'(window_done), 0);

        // Average of 100..400: window_done one cycle after the last sample,
        // the update one cycle after that.
        foreach (samplesA[i]) applyStimulus(0, 1, samplesA[i], 0, 0);
        checkOutput("avg_done", int'(window_done), 1);
        checkOutput("avg_early_update", int'(val_update), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("avg_update", int'(val_update), 1);
        checkOutput("avg_val", int'(val), 250);
        applyStimulus(0, 0, 0, 0, 0);

        // The same four samples in each mode. Mode is different before the
        // last sample, so only the value at window end matters.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(0, 1, samplesB[i], (i == 3) ? modesB[k] : (modesB[k] + 1) % 4, 0);
            end
            applyStimulus(0, 0, 0, modesB[k], 0);
            checkOutput("mode_val", int'(val), expB[k]);
        end

        // Eight back-to-back samples: two windows, results exactly 4 cycles apart.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, samplesC[i], 0, 0);
            if (i == 4) begin
                checkOutput("b2b_first_update", int'(val_update), 1);
                checkOutput("b2b_first_val", int'(val), 1);
            end
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_second_update", int'(val_update), 1);
        checkOutput("b2b_second_val", int'(val), 1000);

        // Millivolt scaling at full scale and at mid scale.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4095, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mv_full_scale", int'(valMv), 999);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 2048, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mv_mid_scale", int'(valMv), 500);

        // freeze over a whole window: the window is reported, but the display is not updated.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 7 * i, 1, 1);
        checkOutput("freeze_done", int'(window_done), 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("freeze_update", int'(val_update), 0);
        checkOutput("freeze_val", int'(val), 2048);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset after 2 samples throws away the partial window.
        applyStimulus(0, 1, 50, 0, 0);
        applyStimulus(0, 1, 60, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 80, 0, 0);
            checkOutput("partial_no_done", int'(window_done), 0);
        end
        applyStimulus(0, 1, 80, 0, 0);
        checkOutput("partial_fourth_done", int'(window_done), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("partial_val", int'(val), 80);

        // Randomized run: gaps, mode changes, freeze and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(($urandom_range(99) < 2),
                          ($urandom_range(99) < 70),
                          int'($urandom_range(4095)),
                          int'($urandom_range(3)),
                          ($urandom_range(99) < 20));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
